adder_psum_packetizer: RTL

- Transmit end of the partial-sum adder's psum packet protocol.
- Collects psums from three PE-side sources (PE0, PE1, PE2), each through its own small buffer.
- Arbitrates among the sources round-robin and emits PWIDTH-bit packets toward the adder node, with the source address code in bits [42:40].
- Each packet is decoded unchanged by the adder-side depacketizer, which dispatches on the source field.

---
 rtl/adder_pkt_pkg.sv | 48 ++++
 rtl/adder_psum_packetizer_fifo.sv | 53 +++++
 rtl/adder_psum_packetizer.sv | 100 ++++++++++
 3 files changed

// File: rtl/adder_pkt_pkg.sv
// Packet field layout and helpers for the adder psum NoC protocol.
// Shared by the packetizer and its input buffers.
package adder_pkt_pkg;

  localparam int PKT_W        = 47;
  localparam int PKT_TYPE_BIT = 46;
  localparam int DEST_MSB     = 45;
  localparam int DEST_LSB     = 43;
  localparam int SRC_MSB      = 42;
  localparam int SRC_LSB      = 40;
  localparam int SEQ_MSB      = 35;
  localparam int SEQ_LSB      = 32;

  localparam logic [2:0] SRC_PE0 = 3'd3;
  localparam logic [2:0] SRC_PE1 = 3'd1;
  localparam logic [2:0] SRC_PE2 = 3'd0;

  function automatic logic [PKT_W-1:0] build_psum_pkt(
    input logic [2:0]  dest,
    input logic [2:0]  src,
    input logic [3:0]  seq,
    input logic [31:0] psum
  );
    logic [PKT_W-1:0] pkt;
    pkt                    = '0;
    pkt[PKT_TYPE_BIT]      = 1'b1;
    pkt[DEST_MSB:DEST_LSB] = dest;
    pkt[SRC_MSB:SRC_LSB]   = src;
    pkt[SEQ_MSB:SEQ_LSB]   = seq;
    pkt[31:0]              = psum;
    return pkt;
  endfunction

  function automatic logic [2:0] src_code(input logic [1:0] idx);
    logic [2:0] c;
    case (idx)
      2'd0:    c = SRC_PE0;
      2'd1:    c = SRC_PE1;
      default: c = SRC_PE2;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] rr3_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/adder_psum_packetizer_fifo.sv
// Per-source psum buffer; ready reflects only the registered fill count.
// Simultaneous push and pop on a non-full buffer leave the count unchanged.
module psum_fifo #(
  parameter int DWIDTH     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              ready,
  input  logic              pop,
  output logic [DWIDTH-1:0] rd_data,
  output logic              empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              wr_en;
  logic              rd_en;

  assign ready   = (count != CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign wr_en   = push && ready;
  assign rd_en   = pop && !empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adder_psum_packetizer.sv
// Three-source round-robin psum packetizer toward the adder node.
// Define ADDER_PKT_SEQ_EN to add per-source 4-bit sequence numbers.
import adder_pkt_pkg::*;

module adder_psum_packetizer #(
  parameter int         DWIDTH     = 8,
  parameter int         PWIDTH     = 47,
  parameter logic [2:0] DEST_ADDR  = 3'b100,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_psum [0:2],
  input  logic [2:0]        in_valid,
  output logic [2:0]        in_ready,
  output logic [PWIDTH-1:0] out_pkt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       pkt_count
);

  logic [DWIDTH-1:0] head [3];
  logic [2:0]        empty;
  logic [2:0]        pop;
  logic [1:0]        rr;
  logic [1:0]        cand;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              load;
  logic [3:0]        seq_val;

  for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
    psum_fifo #(
      .DWIDTH     (DWIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid[gi]),
      .wr_data (in_psum[gi]),
      .ready   (in_ready[gi]),
      .pop     (pop[gi]),
      .rd_data (head[gi]),
      .empty   (empty[gi])
    );
  end

  // Search starts just after the last granted source.
  always_comb begin
    gnt_any = 1'b0;
    gnt     = 2'd0;
    cand    = rr;
    for (int k = 0; k < 3; k++) begin
      cand = rr3_next(cand);
      if (!gnt_any && !empty[cand]) begin
        gnt_any = 1'b1;
        gnt     = cand;
      end
    end
  end

  assign load = gnt_any && (!out_valid || out_ready);
  assign pop  = load ? (3'b001 << gnt) : 3'b000;

`ifdef ADDER_PKT_SEQ_EN
  logic [3:0] seq [3];

  assign seq_val = seq[gnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      seq <= '{default: 4'd0};
    end else if (load) begin
      seq[gnt] <= seq[gnt] + 4'd1;
    end
  end
`else
  assign seq_val = 4'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_pkt   <= '0;
      out_valid <= 1'b0;
      rr        <= 2'd2;
      pkt_count <= '0;
    end else begin
      if (load) begin
        out_pkt   <= build_psum_pkt(DEST_ADDR, src_code(gnt),
                                    seq_val, 32'(head[gnt]));
        out_valid <= 1'b1;
        rr        <= gnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule
